// File: rtl/ahb_names_pkg.sv
// Shared AHB-Lite encodings used by the fabric and its slaves.
package ahb_names_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

endpackage

// File: rtl/ahb_sram_slv_pkg.sv
// Types and helpers for the AHB-Lite to single-port SRAM slave.
package ahb_sram_slv_pkg;

  // state  | meaning
  // IDLE   | no data phase in progress, ready for an address phase
  // WAITST | counting configured wait states before the SRAM access
  // RD     | read data phase: SRAM strobe, then data return
  // WR     | write data phase: SRAM written, transfer completes
  // ERR1   | first ERROR cycle (hreadyout low)
  // ERR2   | second ERROR cycle (hreadyout high)
  typedef enum logic [2:0] {IDLE, WAITST, RD, WR, ERR1, ERR2} state_t;

  localparam int MAX_BYTES = 8;

  // Little-endian byte lanes for a transfer of 2**hsize bytes starting at
  // addr_lsbs. Oversized transfers are flagged as errors elsewhere, so they
  // are simply clamped to a full 64-bit lane set here.
  function automatic logic [MAX_BYTES-1:0] be_gen(input logic [2:0] addr_lsbs,
                                                  input logic [2:0] hsize);
    logic [1:0] sz;
    logic [3:0] nbytes;
    logic [8:0] lanes;
    sz     = (hsize > 3'd3) ? 2'd3 : hsize[1:0];
    nbytes = 4'd1 << sz;
    lanes  = (9'd1 << nbytes) - 9'd1;
    return lanes[7:0] << addr_lsbs;
  endfunction

endpackage

// File: rtl/ahb_sram_slv.sv
// AHB-Lite slave fronting a single-port synchronous SRAM (1-cycle read).
// Optional build macro AHB_SRAM_SLV_PROT_CHECK_EN: user-mode writes to the
// upper half of the window are answered with ERROR and never reach the SRAM.
module ahb_sram_slv
  import ahb_names_pkg::*;
  import ahb_sram_slv_pkg::*;
#(
  parameter int               HADDR  = 32,
  parameter int               HDATA  = 32,
  parameter int               MEM_AW = 10,
  parameter logic [HADDR-1:0] BASE   = '0,
  parameter int               WAIT   = 0
) (
  input  logic                 hclk,
  input  logic                 hreset,
  input  logic                 hsel,
  input  logic [1:0]           htrans,
  input  logic [2:0]           hburst,
  input  logic [2:0]           hsize,
  input  logic [3:0]           hprot,
  input  logic                 hmastlock,
  input  logic [HADDR-1:0]     haddr,
  input  logic                 hwrite,
  input  logic [HDATA-1:0]     hwdata,
  input  logic                 hready,
  output logic [HDATA-1:0]     hrdata,
  output logic                 hresp,
  output logic                 hreadyout,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [MEM_AW-1:0]    mem_addr,
  output logic [HDATA/8-1:0]   mem_be,
  output logic [HDATA-1:0]     mem_wdata,
  input  logic [HDATA-1:0]     mem_rdata
);

  localparam int BYTES   = HDATA / 8;
  localparam int LOG2B   = $clog2(BYTES);
  localparam int WIN_LSB = MEM_AW + LOG2B;
  localparam logic [HADDR:0] WIN_BYTES = {{HADDR{1'b0}}, 1'b1} << WIN_LSB;

  state_t                   state;
  logic [2:0]               cnt;
  logic                     rd_ph;
  logic                     dp_write;
  logic [HDATA-1:0]         hrdata_q;

  logic [HADDR:0]           off_ext;
  logic [HADDR-1:0]         size_mask;
  logic [MEM_AW-1:0]        word_addr;
  logic [2:0]               lane_lsbs;
  logic [MAX_BYTES-1:0]     be_full;
  logic                     acc, acc_err;
  logic                     size_err, align_err, win_err, prot_err;
  logic                     unused_ok;

  // Address below BASE wraps to a huge offset, so one compare covers both ends.
  assign off_ext   = {1'b0, haddr} - {1'b0, BASE};
  assign word_addr = off_ext[LOG2B +: MEM_AW];
  assign size_mask = (HADDR'(1) << hsize) - HADDR'(1);
  assign lane_lsbs = 3'(haddr[LOG2B-1:0]);
  assign be_full   = be_gen(lane_lsbs, hsize);

  assign size_err  = hsize > 3'(LOG2B);
  assign align_err = (haddr & size_mask) != '0;
  assign win_err   = off_ext >= WIN_BYTES;
`ifdef AHB_SRAM_SLV_PROT_CHECK_EN
  assign prot_err  = hwrite && !hprot[1] && word_addr[MEM_AW-1];
`else
  assign prot_err  = 1'b0;
`endif
  assign acc_err   = size_err | align_err | win_err | prot_err;

  // Only one data phase in flight: address phases land only while we are ready.
  assign acc = hsel & hready & htrans[1] & hreadyout;

  assign mem_wdata = (state == WR) ? hwdata : '0;
  assign hrdata    = (state == RD && rd_ph) ? mem_rdata : hrdata_q;

  assign unused_ok = ^{hburst, hmastlock, hprot, htrans[0], off_ext, be_full};

  // Transfer FSM: data-phase sequencing, SRAM strobes and bus response.
  always_ff @(posedge hclk) begin
    if (hreset) begin
      state     <= IDLE;
      cnt       <= '0;
      rd_ph     <= 1'b0;
      dp_write  <= 1'b0;
      hrdata_q  <= '0;
      hreadyout <= 1'b1;
      hresp     <= HRESP_OKAY;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_be    <= '0;
    end else begin
      mem_req <= 1'b0;
      mem_we  <= 1'b0;
      case (state)
        IDLE: begin
          hreadyout <= 1'b1;
          hresp     <= HRESP_OKAY;
        end
        WAITST: begin
          if (cnt == '0) begin
            mem_req   <= 1'b1;
            mem_we    <= dp_write;
            hreadyout <= dp_write;
            rd_ph     <= 1'b0;
            state     <= dp_write ? WR : RD;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        RD: begin
          if (!rd_ph) begin
            rd_ph     <= 1'b1;
            hreadyout <= 1'b1;
          end else begin
            hrdata_q <= mem_rdata;
            state    <= IDLE;
          end
        end
        WR:   state <= IDLE;
        ERR1: begin
          state     <= ERR2;
          hreadyout <= 1'b1;
        end
        ERR2: begin
          state <= IDLE;
          hresp <= HRESP_OKAY;
        end
        default: state <= IDLE;
      endcase

      // A new address phase overrides the default return to IDLE above.
      if (acc) begin
        dp_write <= hwrite;
        if (acc_err) begin
          state     <= ERR1;
          hreadyout <= 1'b0;
          hresp     <= HRESP_ERROR;
        end else begin
          mem_addr <= word_addr;
          mem_be   <= be_full[BYTES-1:0];
          hresp    <= HRESP_OKAY;
          if (WAIT > 0) begin
            state     <= WAITST;
            cnt       <= 3'(WAIT - 1);
            hreadyout <= 1'b0;
          end else if (hwrite) begin
            state     <= WR;
            mem_req   <= 1'b1;
            mem_we    <= 1'b1;
            hreadyout <= 1'b1;
          end else begin
            state     <= RD;
            rd_ph     <= 1'b0;
            mem_req   <= 1'b1;
            hreadyout <= 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: doc/ahb_sram_slv.md
Name: ahb_sram_slv

Overview:
AHB-Lite slave that terminates one slave port of the AHB fabric and maps it onto a single-port synchronous SRAM with one-cycle read latency. It captures the address phase, issues the SRAM access in the data phase and inserts wait states as needed. It also generates the two-cycle ERROR response for illegal transfers. One instance sits downstream of each fabric slv_* port that fronts on-chip memory.

Parameters:
HADDR, 32, AHB address width
HDATA, 32, AHB data width (32 or 64)
MEM_AW, 10, SRAM word-address width (depth 2**MEM_AW words of HDATA)
BASE, 32'h0, byte base address of the window, aligned to the window size
WAIT, 0, extra wait states added before every SRAM access (0..7)

Ports:
hclk  in  1  clock
hreset  in  1  synchronous active-high reset
hsel  in  1  slave select from fabric
htrans  in  2  transfer type
hburst  in  3  burst type (informational; not used for addressing)
hsize  in  3  transfer size
hprot  in  4  protection
hmastlock  in  1  locked transfer (ignored)
haddr  in  HADDR  byte address
hwrite  in  1  1 = write
hwdata  in  HDATA  write data (data phase)
hready  in  1  bus ready (address phase qualifier)
hrdata  out  HDATA  read data
hresp  out  1  0 = OKAY, 1 = ERROR
hreadyout  out  1  slave ready
mem_req  out  1  SRAM access strobe
mem_we  out  1  SRAM write enable
mem_addr  out  MEM_AW  SRAM word address
mem_be  out  HDATA/8  SRAM byte enables
mem_wdata  out  HDATA  SRAM write data
mem_rdata  in  HDATA  SRAM read data, valid the cycle after mem_req with mem_we=0

Behaviour:
- Clocking is fixed: one clock, hclk. Reset is fixed: hreset, synchronous and active-high.
- Reset values: hreadyout=1, hresp=0, hrdata=0, mem_req=0, mem_we=0, mem_addr=0, mem_be=0, mem_wdata=0. The FSM resets to IDLE.
- A reset asserted mid-transfer abandons the transfer. No SRAM access is issued in the cycle after reset.
- Address phase is accepted on the rising edge where hsel & hready & htrans[1] are all 1 (NONSEQ=2, SEQ=3). On accept, register haddr, hsize, hwrite and the error flag.
- IDLE/BUSY transfers with hsel=1 get a zero-wait OKAY and no SRAM access.
- Error condition is any of the following:
  - hsize > log2(HDATA/8)
  - haddr not aligned to hsize
  - haddr outside [BASE, BASE + 2**MEM_AW*HDATA/8)
- FSM states: IDLE, WAITST, RD, WR, ERR1, ERR2.
  - IDLE: hreadyout=1. Accept of an error transfer -> ERR1. Otherwise, WAIT>0 -> WAITST; else read -> RD, write -> WR.
  - WAITST: hreadyout=0; counts WAIT cycles, then -> RD or WR.
  - WR: mem_req=1, mem_we=1, mem_wdata=hwdata, hreadyout=1 in the same cycle. On a new accept in the same edge, go to the next state directly (back-to-back); else -> IDLE.
  - RD: cycle 1 drives mem_req=1, mem_we=0, hreadyout=0. Cycle 2 drives hrdata=mem_rdata, hreadyout=1, and a new accept is allowed.
  - ERR1: hresp=1, hreadyout=0. Next state is ERR2.
  - ERR2: hresp=1, hreadyout=1. A new accept is allowed in ERR2.
- Pipelining: address phases are accepted only on edges where hreadyout=1, so at most one transfer is in data phase.
- Latency: write 0+WAIT wait states; read 1+WAIT; error exactly 1.
- mem_addr = (haddr - BASE) >> log2(HDATA/8), truncated to MEM_AW.
- mem_be: little-endian. Bytes [haddr low bits +: 2**hsize] are set.
- hrdata is a full-width word; the master selects the lanes it needs.
- hrdata holds its last value while not in the RD completion cycle.
- hresp=0 in every state except ERR1/ERR2.

Optional Feature:
AHB_SRAM_SLV_PROT_CHECK_EN
- Defined: a write with hprot[1]=0 (user mode) to the upper half of the window (word-address MSB=1) is an error. It takes the two-cycle ERROR path and the SRAM is not written. User-mode reads are allowed.
- Undefined: hprot is ignored entirely.

Decomposition:
- Use the existing ahb_names_pkg HRESP_OKAY/HRESP_ERROR and HTRANS_IDLE/BUSY/NONSEQ/SEQ constants; add the HTRANS constants there if they are missing.
- New ahb_sram_slv_pkg holds:
  - the state enum (IDLE, WAITST, RD, WR, ERR1, ERR2)
  - a function be_gen(addr_lsbs, hsize) returning the byte-enable vector
- No sub-module; byte-enable generation is a package function.

Test Plan:
- Reset with hsel=1, htrans=NONSEQ held -> all outputs at reset values; first access is only on the first edge after hreset falls.
- WAIT=0, write 32'hDEADBEEF to BASE+4, size=2 -> the data-phase cycle shows mem_req=1, mem_we=1, mem_addr=1, mem_be=4'hF, hreadyout=1.
- Read back BASE+4 -> one cycle hreadyout=0, then hrdata=32'hDEADBEEF, hresp=0.
- Byte write 8'h5A to BASE+7 -> mem_be=4'h8, mem_wdata[31:24]=8'h5A.
- Misaligned halfword at BASE+1, then out-of-window BASE+0x1000 (MEM_AW=10) -> each gives hresp=1/hreadyout=0 then hresp=1/hreadyout=1, with no mem_req.
- WAIT=2, back-to-back SEQ reads -> each completes in 4 cycles with no dropped or duplicated mem_req. With AHB_SRAM_SLV_PROT_CHECK_EN: hprot=4'b0001 write to word 0x200 -> ERROR, SRAM not written.
